// File: rtl/event_pulse_encoder.sv
// Turns single-cycle event strobes into pulses with guaranteed minimum high/low widths.
// Events arriving mid-pulse are queued in a saturating counter and replayed back-to-back.
module event_pulse_encoder #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int MAX_PENDING = 3,
    parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              evt,
    input  logic              clear,
    output logic              out_sig,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic [7:0]        sent_count
);

    localparam int CNT_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  H_LOAD   = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  L_LOAD   = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        sent_q, sent_d;

    logic              start;
    logic              consume;
    logic              direct;
    logic              queue_evt;
    logic              drop;
    logic [PEND_W-1:0] pend_base;

    always_comb begin
        start = (evt | (pending_q != '0)) &
                ((state_q == S_IDLE) | ((state_q == S_LOW) & (cnt_q == '0)));
        consume = start & (pending_q != '0);
        direct  = start & (pending_q == '0);

        // The event accepted with clear is applied on top of the cleared count.
        pend_base = clear ? '0 : (pending_q - PEND_W'(consume));
        queue_evt = evt & ~direct;
        drop      = queue_evt & (pend_base >= PEND_MAX);

        pending_d  = pend_base;
        if (queue_evt && !drop) begin
            pending_d = pend_base + PEND_W'(1);
        end
        overflow_d = (overflow_q & ~clear) | drop;

        sent_d  = start ? (sent_q + 8'd1) : sent_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HIGH;
                    cnt_d   = H_LOAD;
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    cnt_d   = L_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOW: begin
                if (start) begin
                    state_d = S_HIGH;
                    cnt_d   = H_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            sent_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            sent_q     <= sent_d;
        end
    end

    assign out_sig    = (state_q == S_HIGH);
    assign busy       = (state_q != S_IDLE);
    assign pending    = pending_q;
    assign overflow   = overflow_q;
    assign sent_count = sent_q;

endmodule

// File: tb/tb_event_pulse_encoder.sv
// Bench for event_pulse_encoder: vector table, directed corner sequences,
// then random traffic against a pulse-position reference model.
module tb_event_pulse_encoder;

    localparam int H    = 4;
    localparam int L    = 4;
    localparam int MAXP = 3;
    localparam int PW   = $clog2(MAXP + 1);

    logic          clock;
    logic          rst;
    logic          evt;
    logic          clear;
    logic          out_sig;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;
    logic [7:0]    sent_count;

    int n_pass;
    int n_total;

    // Reference: position within current pulse period (-1 = idle), queue depth.
    int m_pos;
    int m_q;
    int m_ov;
    int m_sent;

    event_pulse_encoder #(
        .HIGH_CYCLES(H),
        .LOW_CYCLES (L),
        .MAX_PENDING(MAXP)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .evt       (evt),
        .clear     (clear),
        .out_sig   (out_sig),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow),
        .sent_count(sent_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic e;
        logic c;
        logic r;
        int   out;
        int   bsy;
        int   pnd;
        int   ovf;
        int   snt;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic e, input logic c, input logic r);
        bit can_start;
        bit start;
        bit ev_left;
        if (r) begin
            m_pos  = -1;
            m_q    = 0;
            m_ov   = 0;
            m_sent = 0;
        end else begin
            can_start = (m_pos < 0) || (m_pos == H + L - 1);
            start     = can_start && (e || m_q > 0);
            ev_left   = e;
            if (start) begin
                if (m_q > 0) m_q = m_q - 1;
                else ev_left = 1'b0;
            end
            if (c) begin
                m_q  = 0;
                m_ov = 0;
            end
            if (ev_left) begin
                if (m_q < MAXP) m_q = m_q + 1;
                else m_ov = 1;
            end
            if (start) begin
                m_pos  = 0;
                m_sent = (m_sent + 1) % 256;
            end else if (m_pos >= 0) begin
                m_pos = m_pos + 1;
                if (m_pos == H + L) m_pos = -1;
            end
        end
    endtask

    task automatic step(input logic e, input logic c, input logic r);
        @(negedge clock);
        evt   = e;
        clear = c;
        rst   = r;
        @(posedge clock);
        model_update(e, c, r);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out_sig"}, int'(out_sig), (m_pos >= 0 && m_pos < H) ? 1 : 0);
        chk({tag, ".busy"}, int'(busy), (m_pos >= 0) ? 1 : 0);
        chk({tag, ".pending"}, int'(pending), m_q);
        chk({tag, ".overflow"}, int'(overflow), m_ov);
        chk({tag, ".sent"}, int'(sent_count), m_sent);
    endtask

    vec_t vt[12];
    logic outs[0:63];
    logic bsys[0:63];

    function automatic int rises(input int first, input int last);
        int n;
        n = 0;
        for (int k = first; k <= last; k++) begin
            if (outs[k] && !outs[k-1]) n++;
        end
        return n;
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_pos   = -1;
        m_q     = 0;
        m_ov    = 0;
        m_sent  = 0;
        rst     = 1'b1;
        evt     = 1'b0;
        clear   = 1'b0;

        // Reset with evt held high, then a single event.
        vt[0]  = '{1, 0, 1, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 1, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{1, 0, 0, 1, 1, 0, 0, 1};
        vt[4]  = '{0, 0, 0, 1, 1, 0, 0, 1};
        vt[5]  = '{0, 0, 0, 1, 1, 0, 0, 1};
        vt[6]  = '{0, 0, 0, 1, 1, 0, 0, 1};
        vt[7]  = '{0, 0, 0, 0, 1, 0, 0, 1};
        vt[8]  = '{0, 0, 0, 0, 1, 0, 0, 1};
        vt[9]  = '{0, 0, 0, 0, 1, 0, 0, 1};
        vt[10] = '{0, 0, 0, 0, 1, 0, 0, 1};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 12; i++) begin
            step(vt[i].e, vt[i].c, vt[i].r);
            chk($sformatf("vec%0d.out", i), int'(out_sig), vt[i].out);
            chk($sformatf("vec%0d.busy", i), int'(busy), vt[i].bsy);
            chk($sformatf("vec%0d.pend", i), int'(pending), vt[i].pnd);
            chk($sformatf("vec%0d.ovf", i), int'(overflow), vt[i].ovf);
            chk($sformatf("vec%0d.sent", i), int'(sent_count), vt[i].snt);
        end

        // Burst of three: back-to-back pulses, no idle gap.
        do_reset();
        outs[0] = 1'b0;
        bsys[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(i < 3, 1'b0, 1'b0);
            outs[i+1] = out_sig;
            bsys[i+1] = busy;
            if (i == 2) chk("burst.pending_n3", int'(pending), 2);
        end
        chk("burst.rise1", int'(outs[1] && !outs[0]), 1);
        chk("burst.rise9", int'(outs[9] && !outs[8]), 1);
        chk("burst.rise17", int'(outs[17] && !outs[16]), 1);
        chk("burst.rises", rises(1, 30), 3);
        chk("burst.busy24", int'(bsys[24]), 1);
        chk("burst.busy25", int'(bsys[25]), 0);
        chk("burst.sent", int'(sent_count), 3);

        // Five events in a row: one dropped.
        do_reset();
        outs[0] = 1'b0;
        for (int i = 0; i < 36; i++) begin
            step(i < 5, 1'b0, 1'b0);
            outs[i+1] = out_sig;
            if (i == 4) begin
                chk("ovf.flag_n5", int'(overflow), 1);
                chk("ovf.pending_n5", int'(pending), 3);
            end
        end
        chk("ovf.rises", rises(1, 36), 4);
        chk("ovf.sent", int'(sent_count), 4);
        chk("ovf.busy_end", int'(busy), 0);
        chk("ovf.held", int'(overflow), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("ovf.cleared", int'(overflow), 0);

        // Event exactly on the last LOW cycle restarts immediately.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(i == 0 || i == 8, 1'b0, 1'b0);
            if (i == 7) chk("edge.low_last", int'(out_sig), 0);
        end
        chk("edge.rise", int'(out_sig), 1);
        chk("edge.pending", int'(pending), 0);
        chk("edge.sent", int'(sent_count), 2);

        // Clear while HIGH with two queued: current pulse only.
        do_reset();
        outs[0] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(i < 3, i == 3, 1'b0);
            outs[i+1] = out_sig;
            bsys[i+1] = busy;
            if (i == 2) chk("clr.pending_pre", int'(pending), 2);
            if (i == 3) chk("clr.pending_post", int'(pending), 0);
        end
        chk("clr.high_n4", int'(outs[4]), 1);
        chk("clr.low_n5", int'(outs[5]), 0);
        chk("clr.busy_n9", int'(bsys[9]), 0);
        chk("clr.rises", rises(1, 24), 1);
        chk("clr.sent", int'(sent_count), 1);

        // Reset mid-pulse with queued events.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("rstmid.pending", int'(pending), 1);
        step(1'b1, 1'b0, 1'b1);
        chk("rstmid.out", int'(out_sig), 0);
        chk("rstmid.pending0", int'(pending), 0);
        chk("rstmid.sent0", int'(sent_count), 0);
        outs[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            outs[i+1] = out_sig;
        end
        chk("rstmid.no_pulse", rises(1, 20), 0);
        chk("rstmid.sent_end", int'(sent_count), 0);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 40,
                 $urandom_range(99) < 3,
                 $urandom_range(999) < 5);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
